// File: rtl/mem_access_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | mem_access_ctrl_pkg : opcodes, memory sizing and FSM state encoding   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_access_ctrl_pkg;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  localparam int DMEM_SIZE_DEFAULT = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// +----------------------------------------------------------------------+
// | mem_access_ctrl : LW/SW initiator with single-outstanding req/ack     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DMEM_SIZE = DMEM_SIZE_DEFAULT,
  parameter int TIMEOUT   = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Wdata,
  output logic        wb_valid,
  output logic        err
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic [5:0]       op;
  logic             mem_op;
  logic             in_range;
  logic             unused_ins_bits;

  assign op              = Ins[31:26];
  assign mem_op          = is_mem_op(op);
  assign in_range        = (Result < 32'(DMEM_SIZE));
  assign unused_ins_bits = ^Ins[25:0];

  assign stall = (state == ST_REQ) ||
                 ((state == ST_IDLE) && ex_valid && mem_op && in_range);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      to_cnt    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      Wdata     <= '0;
      wb_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!mem_op) begin
              Wdata    <= Result;
              wb_valid <= 1'b1;
            end else if (in_range) begin
              mem_addr  <= Result;
              mem_wdata <= Rdata2;
              mem_we    <= (op == OP_SW);
              mem_req   <= 1'b1;
              to_cnt    <= '0;
              state     <= ST_REQ;
            end else begin
              // Out-of-range access retires immediately with an error.
              err      <= 1'b1;
              wb_valid <= 1'b1;
              if (op == OP_LW) Wdata <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (!mem_we) Wdata <= mem_rdata;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            state    <= ST_DONE;
          end else if (to_cnt == CNT_LAST) begin
            if (!mem_we) Wdata <= '0;
            mem_req  <= 1'b0;
            err      <= 1'b1;
            wb_valid <= 1'b1;
            state    <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_mem_access_ctrl : scoreboard bench for mem_access_ctrl             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_ctrl;

  localparam int         DMEM    = 256;
  localparam int         TMO     = 16;
  localparam logic [5:0] LW_OP   = 6'h23;
  localparam logic [5:0] SW_OP   = 6'h2B;
  localparam logic [5:0] ADD_OP  = 6'h00;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid;
  logic [31:0] Ins;
  logic [31:0] Result;
  logic [31:0] Rdata2;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] Wdata;
  logic        wb_valid;
  logic        err;

  mem_access_ctrl #(.DMEM_SIZE(DMEM), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .Ins(Ins), .Result(Result),
    .Rdata2(Rdata2), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .Wdata(Wdata), .wb_valid(wb_valid), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] wdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          stall_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] model_wdata = 32'h0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every retirement and checks held request fields.
  always @(negedge CLK) begin
    if (!RST) begin
      if (stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        check("req_we", {31'h0, mem_we}, {31'h0, req_we});
        check("req_addr", mem_addr, req_addr);
        check("req_wdata", mem_wdata, req_wdata);
      end
      if (err && !wb_valid) check("err_without_wb", 32'(err), 32'(0));
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb_valid", 32'(wb_valid), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wb_wdata", Wdata, e.wdata);
          check("wb_err", {31'h0, err}, {31'h0, e.err});
          check("wb_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // waits: number of wait cycles before ack; negative means never ack.
  task automatic issue(input logic [5:0] op, input logic [31:0] res,
                       input logic [31:0] rd2, input int waits,
                       input logic [31:0] rdata);
    bit   is_mem;
    bit   inr;
    int   req_exp;
    exp_t e;
    is_mem    = (op == LW_OP) || (op == SW_OP);
    inr       = (res < 32'(DMEM));
    stall_cnt = 0;
    req_cnt   = 0;
    e.err     = 1'b0;
    req_exp   = 0;
    if (!is_mem) begin
      model_wdata = res;
      e.cyc       = cyc + 1;
    end else if (!inr) begin
      e.err = 1'b1;
      if (op == LW_OP) model_wdata = 32'h0;
      e.cyc = cyc + 1;
    end else begin
      if (waits < 0 || waits >= TMO) begin
        req_exp = TMO;
        e.err   = 1'b1;
        if (op == LW_OP) model_wdata = 32'h0;
      end else begin
        req_exp = waits + 1;
        if (op == LW_OP) model_wdata = rdata;
      end
      e.cyc     = cyc + 1 + req_exp;
      req_we    = (op == SW_OP);
      req_addr  = res;
      req_wdata = rd2;
    end
    e.wdata = model_wdata;
    exp_q.push_back(e);

    ex_valid = 1'b1;
    Ins      = {op, 26'h0};
    Result   = res;
    Rdata2   = rd2;
    @(posedge CLK); #1;
    ex_valid = 1'b0;
    mem_ack  = 1'b0;
    Ins      = 32'h0;
    Result   = 32'h0;
    Rdata2   = 32'h0;
    if (is_mem && inr) begin
      for (int i = 0; i < TMO + 2; i++) begin
        if (!mem_req) break;
        mem_ack   = (i == waits);
        mem_rdata = (i == waits) ? rdata : 32'h0BAD_0BAD;
        @(posedge CLK); #1;
        mem_ack = 1'b0;
        if (i == waits) break;
      end
    end
    repeat (2) @(posedge CLK);
    #1;
    check("stall_cycles", 32'(stall_cnt), (is_mem && inr) ? 32'(req_exp + 1) : 32'(0));
    check("req_cycles", 32'(req_cnt), 32'(req_exp));
  endtask

  initial begin
    RST = 1'b1; ex_valid = 1'b0; Ins = 32'h0; Result = 32'h0; Rdata2 = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_wdata", Wdata, 32'h0);
    check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;

    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    issue(ADD_OP, 32'h0000_1234, 32'h0, 0, 32'h0);

    // Reset in the middle of an unanswered load.
    req_we = 1'b0; req_addr = 32'd5; req_wdata = 32'h0;
    ex_valid = 1'b1; Ins = {LW_OP, 26'h0}; Result = 32'd5; Rdata2 = 32'h0;
    @(posedge CLK); #1;
    ex_valid = 1'b0; Ins = 32'h0; Result = 32'h0;
    check("midreq_req_high", {31'h0, mem_req}, 32'h1);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    model_wdata = 32'h0;
    check("midreq_mem_req", {31'h0, mem_req}, 32'h0);
    check("midreq_stall", {31'h0, stall}, 32'h0);
    check("midreq_mem_addr", mem_addr, 32'h0);
    check("midreq_wdata", Wdata, 32'h0);
    check("midreq_wb_valid", {31'h0, wb_valid}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    issue(ADD_OP, 32'h0000_1234, 32'h0, 0, 32'h0);
    issue(SW_OP, 32'd3, 32'h0000_DEAD, 2, 32'h0);
    issue(LW_OP, 32'd7, 32'h0, 0, 32'd777);
    issue(LW_OP, 32'(DMEM), 32'h0, 0, 32'h0);
    issue(ADD_OP, 32'h0000_0055, 32'h0, 0, 32'h0);
    issue(LW_OP, 32'd9, 32'h0, -1, 32'h0);
    issue(LW_OP, 32'd10, 32'h0, TMO - 1, 32'h0000_CAFE);
    issue(SW_OP, 32'h0000_0100, 32'h1111_2222, 0, 32'h0);
    issue(LW_OP, 32'(DMEM - 1), 32'h0, 1, 32'hA5A5_5A5A);
    issue(SW_OP, 32'd0, 32'hFFFF_0000, -1, 32'h0);
    issue(ADD_OP, 32'hFFFF_FFFF, 32'h0, 0, 32'h0);

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
